// File: rtl/uart_tx_chunk_framer_pkg.sv
// uart_tx_chunk_framer_pkg: MinOS shared definitions for the chunk framer.
// Chunk type codes, framer state encoding and default buffer geometry.
package uart_tx_chunk_framer_pkg;

    typedef enum logic [7:0] {
        CHUNK_LEDS     = 8'd2,
        CHUNK_BUTTONS  = 8'd3,
        CHUNK_SWITCHES = 8'd4,
        CHUNK_DISPLAY  = 8'd6
    } chunk_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } framer_state_e;

    localparam int DEFAULT_BUFFER_BYTES     = 5;
    localparam int DEFAULT_INDEX_BITS       = 32;
    localparam int DEFAULT_SIZE_FIELD_BYTES = 2;

endpackage

// File: rtl/uart_tx_chunk_framer_chunk_byte_selector.sv
// uart_tx_chunk_framer_chunk_byte_selector: maps a frame index to its wire byte.
// Layout: type, size (MSB first), payload 0..size_eff-1, then checksum.
module uart_tx_chunk_framer_chunk_byte_selector #(
    parameter int NB = 5,
    parameter int IW = 32,
    parameter int SF = 2
) (
    input  logic [IW-1:0]   idx,
    input  logic [7:0]      chunk_type,
    input  logic [IW-1:0]   size_eff,
    input  logic [NB*8-1:0] payload,
    input  logic [7:0]      checksum,
    output logic [7:0]      byte_out
);

    // Size field is the low SF bytes of size_eff, so 8*SF must not exceed IW.
    always_comb begin
        byte_out = checksum;
        if (idx == '0)
            byte_out = chunk_type;
        else if (idx <= IW'(SF)) begin
            for (int k = 0; k < SF; k++)
                if (idx == IW'(SF - k)) byte_out = size_eff[8*k +: 8];
        end else if (idx < IW'(SF + 1) + size_eff) begin
            for (int b = 0; b < NB; b++)
                if (idx == IW'(SF + 1 + b)) byte_out = payload[8*b +: 8];
        end
    end

endmodule

// File: rtl/uart_tx_chunk_framer.sv
// uart_tx_chunk_framer: latches one chunk and streams it byte-by-byte to uart_tx.
// Define UART_TX_CHUNK_CHECKSUM_EN to append an XOR checksum byte.
module uart_tx_chunk_framer
    import uart_tx_chunk_framer_pkg::*;
#(
    parameter int CONTENT_BUFFER_BYTE_SIZE  = DEFAULT_BUFFER_BYTES,
    parameter int CONTENT_BUFFER_INDEX_SIZE = DEFAULT_INDEX_BITS,
    parameter int SIZE_FIELD_BYTES          = DEFAULT_SIZE_FIELD_BYTES
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic                                  is_chunk_ready,
    input  logic [7:0]                            chunk_type,
    input  logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    input  logic [CONTENT_BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
    input  logic                                  is_tx_done,
    output logic                                  is_tx_ready,
    output logic [7:0]                            tx_data,
    output logic                                  busy,
    output logic                                  is_chunker_done,
    output logic                                  chunk_dropped
);

    localparam int NB = CONTENT_BUFFER_BYTE_SIZE;
    localparam int IW = CONTENT_BUFFER_INDEX_SIZE;
    localparam int SF = SIZE_FIELD_BYTES;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
    localparam int TAIL = 1;
`else
    localparam int TAIL = 0;
`endif

    framer_state_e   state_q, state_d;
    logic [7:0]      type_q, type_d;
    logic [NB*8-1:0] payload_q, payload_d;
    logic [IW-1:0]   size_q, size_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_ready_q, tx_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dropped_q, dropped_d;
    logic [7:0]      sel_byte;
    logic [IW-1:0]   frame_len;
    logic [IW-1:0]   idx_next;
    logic [IW-1:0]   size_eff;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
    logic [7:0]      checksum_q, checksum_d;
`endif

    assign size_eff  = (chunk_byte_size > IW'(NB)) ? IW'(NB) : chunk_byte_size;
    assign frame_len = IW'(1 + SF + TAIL) + size_q;
    assign idx_next  = idx_q + IW'(1);

    uart_tx_chunk_framer_chunk_byte_selector #(.NB(NB), .IW(IW), .SF(SF)) u_sel (
        .idx        (idx_q),
        .chunk_type (type_q),
        .size_eff   (size_q),
        .payload    (payload_q),
`ifdef UART_TX_CHUNK_CHECKSUM_EN
        .checksum   (checksum_q),
`else
        .checksum   (8'h00),
`endif
        .byte_out   (sel_byte)
    );

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        payload_d  = payload_q;
        size_d     = size_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_ready_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dropped_d  = is_chunk_ready && (state_q != ST_IDLE);
`ifdef UART_TX_CHUNK_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        case (state_q)
            ST_IDLE: if (is_chunk_ready) begin
                type_d    = chunk_type;
                payload_d = chunk_bytes;
                size_d    = size_eff;
                idx_d     = '0;
                busy_d    = 1'b1;
                state_d   = ST_ISSUE;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
                checksum_d = 8'h00;
`endif
            end
            ST_ISSUE: begin
                tx_data_d  = sel_byte;
                tx_ready_d = 1'b1;
                state_d    = ST_WAIT;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
                checksum_d = checksum_q ^ sel_byte;
`endif
            end
            ST_WAIT: if (is_tx_done) begin
                idx_d   = idx_next;
                state_d = (idx_next < frame_len) ? ST_ISSUE : ST_DONE;
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            type_q     <= '0;
            payload_q  <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            payload_q  <= payload_d;
            size_q     <= size_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
`ifdef UART_TX_CHUNK_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    assign is_tx_ready     = tx_ready_q;
    assign tx_data         = tx_data_q;
    assign busy            = busy_q;
    assign is_chunker_done = done_q;
    assign chunk_dropped   = dropped_q;

endmodule
